fp16_to_intn_packer: RTL
========================

FP16_TO_INTN_PACKER -- requirements
Module: fp16_to_intn_packer

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 4, signed output element width, legal range 2..8.
REQ-002 SHALL have parameter PACK_NUM, default 8, number of INT_WIDTH lanes per output word, legal range 1..16.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state rising-edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fp16_i, input, 16, IEEE binary16 element.
REQ-006 SHALL have port in_valid_i, input, 1, fp16_i/in_last_i valid.
REQ-007 SHALL have port in_last_i, input, 1, element closes the current word.
REQ-008 SHALL have port in_ready_o, output, 1, block accepts the element this cycle.
REQ-009 SHALL have port out_data_o, output, INT_WIDTH*PACK_NUM, packed word, lane 0 in LSBs.
REQ-010 SHALL have port out_valid_o, output, 1, out_data_o valid.
REQ-011 SHALL have port out_last_o, output, 1, word was closed by in_last_i.
REQ-012 SHALL have port out_ready_i, input, 1, consumer takes the word.
REQ-013 SHALL have port sat_cnt_o, output, 16, number of saturated or NaN elements since reset, sticks at 16'hFFFF.

Function
REQ-014 SHALL convert each element combinationally: bias 15, value = (-1)^s * 1.m * 2^(e-15) for e in 1..30.
REQ-015 SHALL round to nearest, ties to even (1.5 -> 2, 2.5 -> 2, -0.5 -> 0).
REQ-016 SHALL saturate results outside [-2^(INT_WIDTH-1), 2^(INT_WIDTH-1)-1] to the nearer bound and increment sat_cnt_o.
REQ-017 SHALL map zero and subnormals (e=0) to 0 without incrementing sat_cnt_o.
REQ-018 SHALL map +Inf/-Inf to max/min and NaN to 0, each incrementing sat_cnt_o.
REQ-019 SHALL accept an element on in_valid_i && in_ready_o.
REQ-020 SHALL set in_ready_o = !out_valid_o || out_ready_i.
REQ-021 SHALL write each accepted result into lane lane_cnt of a pack register, lane_cnt counting 0..PACK_NUM-1.
REQ-022 SHALL, when the accepted element is lane PACK_NUM-1 or has in_last_i=1, move the pack register to the output register, assert out_valid_o the next cycle, set out_last_o=in_last_i, zero unused upper lanes, and reset lane_cnt to 0.
REQ-023 SHALL hold out_data_o/out_last_o stable while out_valid_o && !out_ready_i.
REQ-024 SHALL deassert out_valid_o after a handshake unless a new word completes in the same cycle, in which case out_valid_o stays high with the new word (back-to-back, PACK_NUM=1 gives one word per cycle).
REQ-025 SHALL keep FSM states FILL (lane_cnt<PACK_NUM, output empty) and HOLD (output word pending); FILL->HOLD on completion, HOLD->FILL on handshake without new completion, HOLD->HOLD otherwise.
REQ-026 SHALL have latency one cycle from final-element handshake to out_valid_o.

Reset
REQ-027 SHALL, on rst_ni low, immediately clear lane_cnt, pack register, out_data_o, out_last_o, out_valid_o, sat_cnt_o to 0 and enter FILL; in_ready_o becomes 1.
REQ-028 SHALL discard a partially filled or pending word on reset mid-operation.

Structure
REQ-029 SHALL place FP16_BIAS, FP16_EXP_W=5, FP16_MAN_W=10, and an fp16 struct typedef (sign, exp, man) in shared package fp16_intn_pkg.
REQ-030 SHALL implement conversion in combinational sub-module fp16_to_intn_conv (outputs value, sat flag), shared with future quantizers.

Verification (INT_WIDTH=4, PACK_NUM=2 unless noted)
REQ-031 SHALL cover 0x3E00 (1.5), 0x4100 (2.5) -> out_data_o 8'h22, out_valid_o one cycle after second handshake, sat_cnt_o=0.
REQ-032 SHALL cover 0xC200 (-3.0), 0x5640 (100.0) -> 8'h7D, sat_cnt_o=1.
REQ-033 SHALL cover 0xFC00 (-Inf) with in_last_i=1 -> 8'h08, out_last_o=1, sat_cnt_o increments; next 0x7E00 (NaN), 0x0001 (subnormal) -> 8'h00.
REQ-034 SHALL cover out_ready_i=0 for 5 cycles with a word pending -> in_ready_o=0, out_data_o stable, no element lost; release -> next word follows in order.
REQ-035 SHALL cover PACK_NUM=1 with continuous valid/ready -> one word per cycle, out_valid_o continuously high.
REQ-036 SHALL cover rst_ni pulsed low after one lane filled -> out_valid_o=0, next two elements form a fresh word in lanes 0 and 1.

Source files
------------

// File: rtl/fp16_intn_pkg.sv
// Shared fp16 field layout and packer state encoding for the fp16 -> small-int quantizers.
package fp16_intn_pkg;

    localparam int unsigned FP16_BIAS  = 15;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_MAN_W = 10;

    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/fp16_to_intn_conv.sv
// Combinational fp16 -> signed INT_WIDTH conversion, round-to-nearest-even with saturation.
module fp16_to_intn_conv
    import fp16_intn_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 4
) (
    input  logic [15:0]          fp16_i,
    output logic [INT_WIDTH-1:0] value_c,
    output logic                 sat_c
);

    localparam int unsigned FIX_W = 20;
    localparam int unsigned MAG_W = 10;
    localparam logic [FP16_EXP_W-1:0] EXP_HALF = FP16_EXP_W'(FP16_BIAS - 1);
    localparam logic [FP16_EXP_W-1:0] EXP_BIG  = FP16_EXP_W'(FP16_BIAS + 8);
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((1 << (INT_WIDTH - 1)) - 1);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1 << (INT_WIDTH - 1));
    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    fp16_t                 f;
    logic [FP16_MAN_W:0]   sig;
    logic [FIX_W-1:0]      fixed;
    logic [FIX_W-FP16_MAN_W-2:0] int_part;
    logic                  round_up;
    logic [MAG_W-1:0]      mag;
    logic [MAG_W-1:0]      sval;
    logic                  ovf;

    // fixed holds |value| scaled by 2^(MAN_W+1); only exponents 14..22 can land in range
    always_comb begin
        f        = fp16_t'(fp16_i);
        sig      = {1'b1, f.man};
        fixed    = '0;
        int_part = '0;
        round_up = 1'b0;
        mag      = '0;
        sval     = '0;
        ovf      = 1'b0;
        value_c  = '0;
        sat_c    = 1'b0;

        if (f.exp == '1) begin
            sat_c   = 1'b1;
            if (f.man == '0) begin
                value_c = f.sign ? INT_MIN : INT_MAX;
            end
        end else if (f.exp >= EXP_BIG) begin
            sat_c   = 1'b1;
            value_c = f.sign ? INT_MIN : INT_MAX;
        end else if (f.exp >= EXP_HALF) begin
            fixed    = FIX_W'(sig) << (f.exp - EXP_HALF);
            int_part = fixed[FIX_W-1:FP16_MAN_W+1];
            round_up = fixed[FP16_MAN_W] && ((|fixed[FP16_MAN_W-1:0]) || int_part[0]);
            mag      = MAG_W'(int_part) + MAG_W'(round_up);
            ovf      = f.sign ? (mag > NEG_LIM) : (mag > POS_LIM);
            if (ovf) begin
                sat_c   = 1'b1;
                value_c = f.sign ? INT_MIN : INT_MAX;
            end else begin
                sval    = f.sign ? (~mag + MAG_W'(1)) : mag;
                value_c = sval[INT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fp16_to_intn_packer.sv
// Packs PACK_NUM converted fp16 elements into one output word with a single-entry output register.
module fp16_to_intn_packer
    import fp16_intn_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 4,
    parameter int unsigned PACK_NUM  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [15:0]                   fp16_i,
    input  logic                          in_valid_i,
    input  logic                          in_last_i,
    output logic                          in_ready_o,
    output logic [INT_WIDTH*PACK_NUM-1:0] out_data_o,
    output logic                          out_valid_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic [15:0]                   sat_cnt_o
);

    localparam int unsigned DATA_W = INT_WIDTH * PACK_NUM;
    localparam int unsigned LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);

    pack_state_e          state_q, state_d;
    logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
    logic [DATA_W-1:0]    pack_q, pack_d, pack_wr;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic [15:0]          sat_cnt_q, sat_cnt_d;
    logic [INT_WIDTH-1:0] conv_value;
    logic                 conv_sat;
    logic                 accept;
    logic                 complete;

    fp16_to_intn_conv #(
        .INT_WIDTH(INT_WIDTH)
    ) u_conv (
        .fp16_i (fp16_i),
        .value_c(conv_value),
        .sat_c  (conv_sat)
    );

    assign out_valid_o = (state_q == ST_HOLD);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign sat_cnt_o   = sat_cnt_q;
    assign accept      = in_valid_i && in_ready_o;
    assign complete    = accept && ((lane_cnt_q == LAST_LANE) || in_last_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_FILL;
            lane_cnt_q <= '0;
            pack_q     <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            pack_q     <= pack_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // pack register is cleared on completion so lanes above the closing one read as zero
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        pack_d     = pack_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        sat_cnt_d  = sat_cnt_q;
        pack_wr    = pack_q;

        for (int unsigned i = 0; i < PACK_NUM; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                pack_wr[i*INT_WIDTH +: INT_WIDTH] = conv_value;
            end
        end

        case (state_q)
            ST_FILL: if (complete) state_d = ST_HOLD;
            ST_HOLD: begin
                if (complete) begin
                    state_d = ST_HOLD;
                end else if (out_ready_i) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (accept) begin
            if (complete) begin
                out_data_d = pack_wr;
                out_last_d = in_last_i;
                pack_d     = '0;
                lane_cnt_d = '0;
            end else begin
                pack_d     = pack_wr;
                lane_cnt_d = lane_cnt_q + LANE_W'(1);
            end
            if (conv_sat && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

endmodule
